// File: rtl/pixel_write_collector.sv
// Collects clipped drawer pixels into a small FIFO and drains them to the framebuffer port,
// with a full-screen clear sequencer. Optional key-color discard: define TRANSPARENT_COLOR_EN.
module pixel_write_collector #(
  parameter int          SCREEN_W    = 320,
  parameter int          SCREEN_H    = 240,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [2:0]  CLEAR_COLOR = 3'b000,
  parameter logic [2:0]  TRANSPARENT = 3'b101
) (
  input  logic        iCLOCK_50,
  input  logic        iresetn,
  input  logic [8:0]  ix,
  input  logic [7:0]  iy,
  input  logic [2:0]  icolor,
  input  logic        iwriteEn,
  input  logic        iclearEn,
  input  logic        imemReady,
  output logic [16:0] oaddr,
  output logic [2:0]  odata,
  output logic        owren,
  output logic        ofull,
  output logic        oempty,
  output logic        oclearDone,
  output logic [7:0]  odropCount
);

  localparam int          PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [8:0]  W_LIM      = 9'(SCREEN_W);
  localparam logic [7:0]  H_LIM      = 8'(SCREEN_H);
  localparam logic [16:0] CLEAR_LAST = 17'(SCREEN_W * SCREEN_H - 1);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef TRANSPARENT_COLOR_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_idle,
    ST_clear,
    ST_clearDone
  } state_e;

  typedef struct packed {
    logic [16:0] addr;
    logic [2:0]  color;
  } pix_t;

  state_e           state_q, state_d;
  logic [16:0]      clr_cnt_q, clr_cnt_d;
  logic             clr_block_q, clr_block_d;
  logic [16:0]      addr_q, addr_d;
  logic [2:0]       data_q, data_d;
  logic             wren_q, wren_d;
  logic             done_q, done_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  pix_t             fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, empty_q;

  logic             in_bounds, key_hit, candidate;
  logic             push, pop, drop;
  logic [16:0]      y_wide, pix_addr;
  pix_t             head;

  // Shift-add form of y*320; the clip below guarantees the sum stays under 76800.
  always_comb begin
    y_wide   = {9'b0, iy};
    pix_addr = (y_wide << 8) + (y_wide << 6) + {8'b0, ix};
  end

  assign in_bounds = (ix < W_LIM) && (iy < H_LIM);
  assign key_hit   = KEY_EN && (icolor == TRANSPARENT);
  assign candidate = iwriteEn && in_bounds && !key_hit;
  assign head      = fifo_mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push = candidate && (!full_q || pop);
  assign drop = candidate && full_q && !pop;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_block_d = clr_block_q && iclearEn;
    addr_d      = addr_q;
    data_d      = data_q;
    wren_d      = 1'b0;
    done_d      = 1'b0;
    pop         = 1'b0;

    unique case (state_q)
      ST_idle: begin
        if (iclearEn && !clr_block_q) begin
          state_d     = ST_clear;
          clr_cnt_d   = '0;
          clr_block_d = 1'b1;
        end else if (!empty_q && imemReady) begin
          pop    = 1'b1;
          addr_d = head.addr;
          data_d = head.color;
          wren_d = 1'b1;
        end
      end
      ST_clear: begin
        if (imemReady) begin
          addr_d = clr_cnt_q;
          data_d = CLEAR_COLOR;
          wren_d = 1'b1;
          if (clr_cnt_q == CLEAR_LAST) begin
            state_d = ST_clearDone;
          end else begin
            clr_cnt_d = clr_cnt_q + 17'd1;
          end
        end
      end
      ST_clearDone: begin
        done_d  = 1'b1;
        state_d = ST_idle;
      end
      default: state_d = ST_idle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge iCLOCK_50 or negedge iresetn) begin
    if (!iresetn) begin
      state_q     <= ST_idle;
      clr_cnt_q   <= '0;
      clr_block_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
      done_q      <= 1'b0;
      drop_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_block_q <= clr_block_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      done_q      <= done_d;
      drop_cnt_q  <= drop_cnt_d;
      count_q     <= count_d;
      full_q      <= (count_d == DEPTH_L);
      empty_q     <= (count_d == '0);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage array is not reset; the pointers and count define which entries are valid.
  always_ff @(posedge iCLOCK_50) begin
    if (push) fifo_mem_q[wr_ptr_q] <= '{addr: pix_addr, color: icolor};
  end

  assign oaddr      = addr_q;
  assign odata      = data_q;
  assign owren      = wren_q;
  assign ofull      = full_q;
  assign oempty     = empty_q;
  assign oclearDone = done_q;
  assign odropCount = drop_cnt_q;

endmodule

// File: tb/tb_pixel_write_collector.sv
// Directed bench for pixel_write_collector: clip, address, FIFO full/drop, clear, async reset, key color.
module tb_pixel_write_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  ix;
  logic [7:0]  iy;
  logic [2:0]  icolor;
  logic        iwriteEn, iclearEn, imemReady;
  logic [16:0] oaddr;
  logic [2:0]  odata;
  logic        owren, ofull, oempty, oclearDone;
  logic [7:0]  odropCount;

  int checks = 0;
  int errors = 0;

  pixel_write_collector dut (
    .iCLOCK_50 (clk),
    .iresetn   (rst_n),
    .ix        (ix),
    .iy        (iy),
    .icolor    (icolor),
    .iwriteEn  (iwriteEn),
    .iclearEn  (iclearEn),
    .imemReady (imemReady),
    .oaddr     (oaddr),
    .odata     (odata),
    .owren     (owren),
    .ofull     (ofull),
    .oempty    (oempty),
    .oclearDone(oclearDone),
    .odropCount(odropCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int x, input int y, input logic [2:0] c);
    ix       = 9'(x);
    iy       = 8'(y);
    icolor   = c;
    iwriteEn = 1'b1;
  endtask

  initial begin
    int bad;
    logic [2:0] col;

    rst_n = 1'b0; ix = '0; iy = '0; icolor = '0;
    iwriteEn = 1'b0; iclearEn = 1'b0; imemReady = 1'b1;
    repeat (3) step();
    check("rst_owren", owren, 0);
    check("rst_oaddr", oaddr, 0);
    check("rst_odata", odata, 0);
    check("rst_ofull", ofull, 0);
    check("rst_oempty", oempty, 1);
    check("rst_done", oclearDone, 0);
    check("rst_drop", odropCount, 0);
    rst_n = 1'b1;
    step();

    // Single pixel: one-cycle latency to owren.
    pixel(5, 86, 3'b100);
    step();
    iwriteEn = 1'b0;
    check("p1_not_empty", oempty, 0);
    check("p1_no_wren_yet", owren, 0);
    step();
    check("p1_wren", owren, 1);
    check("p1_addr", oaddr, 27525);
    check("p1_data", odata, 3'b100);
    check("p1_empty_after", oempty, 1);
    step();
    check("p1_wren_off", owren, 0);
    check("p1_drop", odropCount, 0);

    // In-bounds pixel followed by one clipped at x=320.
    pixel(298, 137, 3'b010);
    step();
    pixel(320, 10, 3'b011);
    step();
    iwriteEn = 1'b0;
    check("p2_wren", owren, 1);
    check("p2_addr", oaddr, 44138);
    step();
    check("clip_no_wren", owren, 0);
    check("clip_empty", oempty, 1);
    check("clip_no_drop", odropCount, 0);

    // Stall the memory: 8 fill the FIFO, 2 are dropped.
    imemReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pixel(i + 1, 1, (i % 2 == 1) ? 3'b011 : 3'b110);
      step();
      if (i == 6) check("fill7_not_full", ofull, 0);
      if (i == 7) check("fill8_full", ofull, 1);
    end
    iwriteEn = 1'b0;
    check("fill_drop2", odropCount, 2);
    check("fill_no_wren", owren, 0);
    // Release the stall while pushing once more: push and pop share the edge on a full FIFO.
    imemReady = 1'b1;
    pixel(50, 1, 3'b010);
    step();
    iwriteEn = 1'b0;
    check("drain0_wren", owren, 1);
    check("drain0_addr", oaddr, 321);
    check("drain0_data", odata, 3'b110);
    check("full_push_pop_full", ofull, 1);
    check("full_push_pop_nodrop", odropCount, 2);
    for (int j = 1; j < 8; j++) begin
      step();
      col = (j % 2 == 1) ? 3'b011 : 3'b110;
      check("drain_wren", owren, 1);
      check("drain_addr", oaddr, 321 + j);
      check("drain_data", odata, col);
    end
    step();
    check("drain_extra_addr", oaddr, 370);
    check("drain_extra_data", odata, 3'b010);
    check("drain_empty", oempty, 1);
    step();
    check("drain_idle", owren, 0);

    // Full clear with a pixel injected mid-way; clear request stays high throughout.
    iclearEn = 1'b1;
    step();
    check("clr_enter_no_wren", owren, 0);
    bad = 0;
    for (int n = 0; n < 76800; n++) begin
      step();
      if (owren !== 1'b1 || oaddr !== 17'(n) || odata !== 3'b000 || oclearDone !== 1'b0) bad++;
      if (n == 100) pixel(194, 218, 3'b011);
      else if (n == 101) iwriteEn = 1'b0;
    end
    check("clr_write_errors", bad, 0);
    check("clr_pixel_held", oempty, 0);
    step();
    check("clr_done_pulse", oclearDone, 1);
    check("clr_done_no_wren", owren, 0);
    step();
    check("clr_done_once", oclearDone, 0);
    check("post_clr_wren", owren, 1);
    check("post_clr_addr", oaddr, 69954);
    check("post_clr_data", odata, 3'b011);
    step();
    check("no_reclear_wren", owren, 0);
    check("no_reclear_empty", oempty, 1);
    iclearEn = 1'b0;
    step();

    // Async reset mid-clear abandons both the clear and the buffered pixel.
    iclearEn = 1'b1;
    step();
    for (int n = 0; n < 1000; n++) begin
      step();
      if (n == 500) pixel(7, 7, 3'b001);
      else if (n == 501) iwriteEn = 1'b0;
    end
    check("midclr_addr", oaddr, 999);
    check("midclr_pending", oempty, 0);
    rst_n = 1'b0;
    #1;
    check("arst_owren", owren, 0);
    check("arst_oempty", oempty, 1);
    check("arst_oaddr", oaddr, 0);
    #10;
    rst_n = 1'b1;
    step();
    check("restart_enter", owren, 0);
    step();
    check("restart_wren", owren, 1);
    check("restart_addr0", oaddr, 0);
    step();
    check("restart_addr1", oaddr, 1);
    iclearEn = 1'b0;
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
    step();

    // Key-colored pixel.
    pixel(10, 10, 3'b101);
    step();
    iwriteEn = 1'b0;
    step();
`ifdef TRANSPARENT_COLOR_EN
    check("key_no_wren", owren, 0);
    check("key_empty", oempty, 1);
`else
    check("key_wren", owren, 1);
    check("key_addr", oaddr, 3210);
    check("key_data", odata, 3'b101);
`endif
    check("key_no_drop", odropCount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_write_collector.md
Name: pixel_write_collector

Overview:
- Receiving end of the sprite-drawer pixel stream (x, y, color, writeEn).
- Each drawer FSM emits one strobed pixel per write cycle. This block:
  - samples those strobes;
  - clips them to the 320x240 screen;
  - converts coordinates to a linear framebuffer address;
  - buffers them in a small FIFO;
  - drains them to the framebuffer memory port.
- Also provides a full-screen clear sequencer, used before the initial screen and the hearts and round-number sprites are drawn.

Parameters:
- SCREEN_W, 320, visible width in pixels.
- SCREEN_H, 240, visible height in pixels.
- FIFO_DEPTH, 8, pixel buffer entries; power of 2.
- CLEAR_COLOR, 3'b000, color written by the clear sequence.
- TRANSPARENT, 3'b101, key color; used only with the optional feature.

Ports:
- iCLOCK_50  in  1  system clock; all logic on the rising edge.
- iresetn  in  1  asynchronous, active-low reset.
- ix  in  9  pixel x from the drawer.
- iy  in  8  pixel y from the drawer.
- icolor  in  3  pixel color from the drawer.
- iwriteEn  in  1  pixel strobe; one pixel is sampled per cycle while high.
- iclearEn  in  1  request a full-screen clear; level, sampled only in ST_idle.
- imemReady  in  1  framebuffer accepts a write this cycle.
- oaddr  out  17  framebuffer address, y*320+x.
- odata  out  3  framebuffer write data.
- owren  out  1  framebuffer write strobe.
- ofull  out  1  FIFO full.
- oempty  out  1  FIFO empty.
- oclearDone  out  1  one-cycle pulse when the clear completes.
- odropCount  out  8  saturating count of dropped pixels.

Behaviour:
- Reset (async, iresetn=0):
  - state=ST_idle, FIFO empty;
  - oaddr=0, odata=0, owren=0;
  - ofull=0, oempty=1, oclearDone=0, odropCount=0.
  - Reset mid-clear or mid-drain abandons all pending work.
- Input sampling, on each edge with iwriteEn=1:
  - ix>=SCREEN_W or iy>=SCREEN_H: silently discarded; not a drop.
  - Otherwise, FIFO full: pixel discarded and odropCount incremented; saturates at 255.
  - Otherwise: push {addr, color}.
- Address arithmetic:
  - addr = (iy<<8) + (iy<<6) + ix, computed at the push.
  - 17 bits; the maximum is 76799, so it never wraps.
- Pixels sampled during ST_clear are still pushed; they are drained after the clear completes.
- FSM states: ST_idle, ST_clear, ST_clearDone.
  - ST_idle:
    - iclearEn=1 -> ST_clear, clear counter=0. The clear has priority over the drain on the same edge.
    - Else, FIFO non-empty and imemReady=1 -> pop the head, load oaddr/odata, owren=1.
    - Else owren=0.
  - ST_clear, each edge:
    - imemReady=1: oaddr=counter, odata=CLEAR_COLOR, owren=1, counter+1.
    - imemReady=0: owren=0, counter held.
    - After writing address 76799 -> ST_clearDone.
  - ST_clearDone: oclearDone=1 for exactly one cycle, owren=0, -> ST_idle. A clear request must drop and reassert to start another clear.
- Latency:
  - Pixel sampled at edge k, FIFO previously empty, imemReady=1: owren high from edge k+1 to k+2.
  - Sustained throughput is 1 pixel/cycle.
- Simultaneous push and pop when full: the pop frees the slot and the push is accepted; no drop.
- Simultaneous push and pop when empty: the push is accepted and the pop is not performed, since the FIFO was empty at that edge.
- ofull and oempty are registered and reflect the occupancy after each edge.
- Full clear takes 76800 write cycles plus stalls, plus 1 cycle to ST_clearDone.

Optional Feature:
- Macro TRANSPARENT_COLOR_EN.
- Defined: an in-bounds pixel with icolor==TRANSPARENT is discarded at sampling. It is not pushed, not counted as a drop, and leaves the framebuffer unchanged. This lets sprites carry key-colored backgrounds.
- Undefined: TRANSPARENT is ignored and every in-bounds pixel is pushed.

Test Plan:
- Reset, then iwriteEn=1 for one cycle with ix=5, iy=86, icolor=3'b100, imemReady=1 -> one owren pulse, oaddr=27525, odata=3'b100, odropCount=0.
- Pixel at (298,137) and pixel at (320,10) -> the first writes oaddr=44138; the second is clipped with no owren and no odropCount increment.
- imemReady=0, then 10 consecutive valid pixels -> ofull=1 after 8; odropCount=2. Release imemReady -> 8 writes in push order, then oempty=1.
- iclearEn=1 with imemReady=1 -> 76800 consecutive writes, oaddr 0..76799, odata=CLEAR_COLOR, then a single oclearDone pulse. A pixel at (194,218) pushed mid-clear is written at oaddr=69954 after oclearDone.
- Assert iresetn=0 asynchronously during a clear at counter 1000 -> owren=0 immediately, FIFO empty, state ST_idle. A new clear restarts at oaddr=0.
- With TRANSPARENT_COLOR_EN defined, pixel (10,10) with icolor=3'b101 -> no owren. Without the macro -> written at oaddr=3210.
